next_pc_unit: RTL and testbench

Registered program-counter stage for the MIPS single-cycle core. It sits directly downstream of the branch-offset left-shift stage, consuming its word-aligned byte offset.
- Computes PC+4, the branch target, the jump target and the jump-register target.
- Selects the next PC by fixed priority and holds it in a register.
- Adds stall, halt/resume and exception-redirect control around the PC register.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pc_target_calc.sv | 49 ++++
 rtl/next_pc_unit.sv | 118 +++++++++++
 tb/tb_next_pc_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS PC stage: state encoding, word width,
// default reset/exception addresses and next-PC path selection codes.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEF_EXC_VECTOR = 32'h0000_0080;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_EXC    = 3'd0,
    SEL_JR_MIS = 3'd1,
    SEL_JR     = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_BRANCH = 3'd4,
    SEL_SEQ    = 3'd5
  } sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC calculation: pc+4, branch/jump/jr targets and the
// fixed-priority selection of the next PC.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic [WORD_W-1:0] pc,
  input  logic              exception,
  input  logic              jr,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_offset_sl2,
  output logic [WORD_W-1:0] pc_plus4,
  output logic [WORD_W-1:0] next_pc,
  output sel_t              sel
);

  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] jump_target;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + branch_offset_sl2;
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    sel     = SEL_SEQ;
    if (exception) begin
      next_pc = EXC_VECTOR;
      sel     = SEL_EXC;
    end else if (jr && (jr_target[1:0] != 2'b00)) begin
      next_pc = EXC_VECTOR;
      sel     = SEL_JR_MIS;
    end else if (jr) begin
      next_pc = jr_target;
      sel     = SEL_JR;
    end else if (jump) begin
      next_pc = jump_target;
      sel     = SEL_JUMP;
    end else if (branch_taken) begin
      next_pc = branch_target;
      sel     = SEL_BRANCH;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Registered program counter with BOOT/RUN/HALTED control, stall and exception
// redirect. Define BRANCH_STATS_EN to add saturating taken/redirect counters.
module next_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        halted,
  output logic        misaligned
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] taken_count,
  output logic [31:0] redirect_count
`endif
);

  state_t            state;
  logic [WORD_W-1:0] next_pc;
  sel_t              sel;

  pc_target_calc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_calc (
    .pc               (pc),
    .exception        (exception),
    .jr               (jr),
    .jr_target        (jr_target),
    .jump             (jump),
    .jump_index       (jump_index),
    .branch_taken     (branch_taken),
    .branch_offset_sl2(branch_offset_sl2),
    .pc_plus4         (pc_plus4),
    .next_pc          (next_pc),
    .sel              (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      state      <= BOOT;
      pc_valid   <= 1'b0;
      halted     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end
        RUN: begin
          // Exception overrides stall and halt_req; a stalled cycle retires
          // nothing, so halt_req only takes effect when the PC advances.
          if (exception) begin
            pc <= next_pc;
          end else if (!stall) begin
            pc         <= next_pc;
            misaligned <= (sel == SEL_JR_MIS);
            if (halt_req) begin
              state    <= HALTED;
              halted   <= 1'b1;
              pc_valid <= 1'b0;
            end
          end
        end
        HALTED: begin
          if (exception || resume) begin
            if (exception) pc <= next_pc;
            state    <= RUN;
            halted   <= 1'b0;
            pc_valid <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic pc_load;

  assign pc_load = ((state == RUN) && (exception || !stall)) ||
                   ((state == HALTED) && exception);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (pc_load && (sel == SEL_BRANCH) && (taken_count != '1))
        taken_count <= taken_count + 32'd1;
      if (pc_load && (sel != SEL_SEQ) && (redirect_count != '1))
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: table of single-cycle redirect vectors
// plus hand sequences for reset, halt/resume and the optional counters.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset_sl2;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        halted;
  logic        misaligned;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] redirect_count;
`endif

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  next_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_offset_sl2(branch_offset_sl2),
    .jump             (jump),
    .jump_index       (jump_index),
    .jr               (jr),
    .jr_target        (jr_target),
    .exception        (exception),
    .halt_req         (halt_req),
    .resume           (resume),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .pc_valid         (pc_valid),
    .halted           (halted),
    .misaligned       (misaligned)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count      (taken_count),
    .redirect_count   (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic        stall;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic        exc;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_offset_sl2 = '0;
    jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;
    exception = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  // Force pc to an aligned address through a jr.
  task automatic load_pc(input logic [31:0] addr);
    idle_inputs();
    jr = 1'b1; jr_target = addr;
    tick();
    idle_inputs();
    check("load_pc", pc, addr);
  endtask

  task automatic apply(input int unsigned i, input vec_t v);
    string nm;
    load_pc(v.start);
    stall = v.stall; branch_taken = v.br; branch_offset_sl2 = v.off;
    jump = v.jmp; jump_index = v.idx; jr = v.jr; jr_target = v.jrt;
    exception = v.exc;
    tick();
    idle_inputs();
    nm = $sformatf("vec%0d_pc", i);
    check(nm, pc, v.exp_pc);
    nm = $sformatf("vec%0d_pc_plus4", i);
    check(nm, pc_plus4, v.exp_pc + 32'd4);
    nm = $sformatf("vec%0d_misaligned", i);
    check(nm, {31'd0, misaligned}, {31'd0, v.exp_mis});
  endtask

  task automatic go_halted(input logic [31:0] addr);
    load_pc(addr);
    halt_req = 1'b1;
    tick();
    idle_inputs();
    check("halt_enter_halted", {31'd0, halted}, 32'd1);
    check("halt_enter_pc", pc, addr + 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          start          stl  br   off            jmp  idx           jr   jrt            exc  exp_pc         mis
    vt[0]  = '{32'h0040_0010, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0,       1'b0, 32'h0,         1'b0, 32'h0040_0004, 1'b0};
    vt[1]  = '{32'h0040_0010, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0,       1'b0, 32'h0,         1'b0, 32'h0040_0010, 1'b0};
    vt[2]  = '{32'h1000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 26'h000_0040, 1'b0, 32'h0,        1'b0, 32'h1000_0100, 1'b0};
    vt[3]  = '{32'h0000_1000, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_2002, 1'b0, 32'h0000_0080, 1'b1};
    vt[4]  = '{32'h0000_1000, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_2000, 1'b0, 32'h0000_2000, 1'b0};
    vt[5]  = '{32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0};
    vt[6]  = '{32'h0000_0400, 1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       1'b0, 32'h0,         1'b1, 32'h0000_0080, 1'b0};
    vt[7]  = '{32'h0000_0300, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_2000, 1'b1, 32'h0000_0080, 1'b0};
    vt[8]  = '{32'h0000_0100, 1'b0, 1'b0, 32'h0,         1'b1, 26'h000_0001, 1'b1, 32'h0000_4000, 1'b0, 32'h0000_4000, 1'b0};
    vt[9]  = '{32'hFFFF_FFF0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 26'h0,       1'b0, 32'h0,         1'b0, 32'h0000_0014, 1'b0};
    vt[10] = '{32'hF000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 1'b0};
    vt[11] = '{32'h0000_0500, 1'b1, 1'b0, 32'h0,         1'b1, 26'h000_0010, 1'b0, 32'h0,        1'b0, 32'h0000_0500, 1'b0};
    vt[12] = '{32'h0000_0600, 1'b1, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_2001, 1'b0, 32'h0000_0600, 1'b0};
    vt[13] = '{32'h0000_0600, 1'b0, 1'b0, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0000_2001, 1'b0, 32'h0000_0080, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    #20;
    check("reset_pc", pc, 32'h0);
    check("reset_pc_valid", {31'd0, pc_valid}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_misaligned", {31'd0, misaligned}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("reset_taken_count", taken_count, 32'd0);
    check("reset_redirect_count", redirect_count, 32'd0);
`endif
    #2 rst_n = 1'b1;

    // BOOT cycle (stall ignored), then sequential fetch
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("boot_pc", pc, 32'h0);
    check("boot_pc_valid", {31'd0, pc_valid}, 32'd1);
    tick();
    check("seq1_pc", pc, 32'h4);
    tick();
    check("seq2_pc", pc, 32'h8);

    for (int i = 0; i < 14; i++) apply(i, vt[i]);

    // misaligned is a single-cycle pulse
    tick();
    check("misaligned_drop", {31'd0, misaligned}, 32'd0);
    check("after_mis_pc", pc, 32'h84);

    // halt: pc frozen for 5 cycles despite redirect inputs
    go_halted(32'h0000_0800);
    check("halt_pc_valid", {31'd0, pc_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      jump = 1'b1; jump_index = 26'h000_0123; branch_taken = 1'b1; halt_req = 1'b1;
      tick();
      check("halted_hold_pc", pc, 32'h0000_0804);
      check("halted_hold_flag", {31'd0, halted}, 32'd1);
    end
    idle_inputs();
    halt_req = 1'b1; resume = 1'b1;
    tick();
    idle_inputs();
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_pc_valid", {31'd0, pc_valid}, 32'd1);
    check("resume_pc", pc, 32'h0000_0804);
    tick();
    check("resume_next_pc", pc, 32'h0000_0808);

    // halt_req with exception in RUN: exception wins, stays in RUN
    load_pc(32'h0000_0900);
    halt_req = 1'b1; exception = 1'b1;
    tick();
    idle_inputs();
    check("halt_exc_pc", pc, 32'h80);
    check("halt_exc_halted", {31'd0, halted}, 32'd0);

    // exception in HALTED redirects and returns to RUN
    go_halted(32'h0000_0A00);
    exception = 1'b1;
    tick();
    idle_inputs();
    check("halted_exc_pc", pc, 32'h80);
    check("halted_exc_halted", {31'd0, halted}, 32'd0);
    check("halted_exc_valid", {31'd0, pc_valid}, 32'd1);

    // asynchronous reset mid-cycle while HALTED, with a redirect pending
    go_halted(32'h0000_0B00);
    exception = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_halted", {31'd0, halted}, 32'd0);
    check("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_boot_pc", pc, 32'h0);
    check("post_rst_valid", {31'd0, pc_valid}, 32'd1);

`ifdef BRANCH_STATS_EN
    check("stats_zero_taken", taken_count, 32'd0);
    check("stats_zero_redirect", redirect_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      branch_taken = 1'b1; branch_offset_sl2 = 32'h10;
      tick();
    end
    idle_inputs();
    check("stats_branch_pc", pc, 32'h3C);
    jump = 1'b1; jump_index = 26'h0;
    tick();
    idle_inputs();
    check("stats_jump_pc", pc, 32'h0);
    // a stalled branch must not count
    stall = 1'b1; branch_taken = 1'b1; branch_offset_sl2 = 32'h10;
    tick();
    idle_inputs();
    tick();
    check("stats_taken_count", taken_count, 32'd3);
    check("stats_redirect_count", redirect_count, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
